// File: rtl/calc_pkg.sv
// Shared constants, opcodes and FSM state type for the calculator command sequencer.
package calc_pkg;
  localparam int DATA_W     = 8;
  localparam int PROG_DEPTH = 16;
  localparam int ADDR_W     = 4;
  localparam int OP_W       = 3;
  localparam int INSTR_W    = OP_W + DATA_W;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(PROG_DEPTH);

  localparam logic [OP_W-1:0] OP_SHOW_IN  = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD      = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB      = 3'b010;
  localparam logic [OP_W-1:0] OP_SHOW_ACC = 3'b011;
  localparam logic [OP_W-1:0] OP_HOLD     = 3'b111;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  // Only the two show opcodes make the calculator present something worth capturing.
  function automatic logic is_show(input logic [OP_W-1:0] op);
    return (op == OP_SHOW_IN) || (op == OP_SHOW_ACC);
  endfunction
endpackage

// File: rtl/calc_prog_mem.sv
// Instruction store: synchronous write, asynchronous read, contents survive reset.
module calc_prog_mem
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);
  logic [INSTR_W-1:0] r_mem [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/calculadora_sequenciador.sv
// Runs a stored program against the accumulator calculator and streams back show results.
// Result handshake: res_valid is a one-cycle strobe with res_data/res_index; no backpressure.
module calculadora_sequenciador
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_instr,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               calc_rst,
  output logic [DATA_W-1:0]  calc_entrada,
  output logic [OP_W-1:0]    calc_codigo,
  input  logic [DATA_W-1:0]  calc_saida,
  output logic               res_valid,
  output logic [DATA_W-1:0]  res_data,
  output logic [ADDR_W-1:0]  res_index,
  output state_t             dbg_state
);
  state_t             r_state, w_next;
  logic [ADDR_W:0]    r_pc, r_len;
  logic [INSTR_W-1:0] w_instr;
  logic               w_start, w_we, w_issue;
  logic               r_pend0, r_pend1;
  logic [ADDR_W-1:0]  r_res_cnt, r_res_index;
  logic [DATA_W-1:0]  r_res_data, r_calc_entrada;
  logic [OP_W-1:0]    r_calc_codigo;
  logic               r_busy, r_done, r_calc_rst, r_res_valid;

  assign w_start = (r_state == IDLE) && start;
  assign w_we    = (r_state == IDLE) && prog_we;
  assign w_issue = ((r_state == CLEAR) || (r_state == RUN)) && (r_pc < r_len);

  calc_prog_mem u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_instr),
    .i_raddr (r_pc[ADDR_W-1:0]),
    .o_rdata (w_instr)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (start) w_next = CLEAR;
      CLEAR, RUN: w_next = w_issue ? RUN : DRAIN;
      DRAIN:      if (!r_pend0) w_next = DONE;
      DONE:       w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_calc_rst     <= 1'b0;
      r_calc_codigo  <= OP_HOLD;
      r_calc_entrada <= '0;
      r_pc           <= '0;
      r_len          <= '0;
      r_pend0        <= 1'b0;
      r_pend1        <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_res_index    <= '0;
      r_res_cnt      <= '0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != IDLE);
      r_done     <= (w_next == DONE);
      r_calc_rst <= (w_next == CLEAR);

      if (w_start) begin
        r_pc        <= '0;
        r_len       <= (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
        r_res_cnt   <= '0;
        r_res_index <= '0;
      end

      if (w_issue) begin
        r_calc_codigo  <= w_instr[INSTR_W-1 -: OP_W];
        r_calc_entrada <= w_instr[DATA_W-1:0];
        r_pend0        <= is_show(w_instr[INSTR_W-1 -: OP_W]);
        r_pc           <= r_pc + 1'b1;
      end else begin
        r_calc_codigo  <= OP_HOLD;
        r_calc_entrada <= '0;
        r_pend0        <= 1'b0;
      end

      // pend0 tracks the instruction on the bus, pend1 the cycle its saida becomes valid.
      r_pend1     <= r_pend0;
      r_res_valid <= r_pend1;
      if (r_pend1) begin
        r_res_data  <= calc_saida;
        r_res_index <= r_res_cnt;
        r_res_cnt   <= r_res_cnt + 1'b1;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign calc_rst     = r_calc_rst;
  assign calc_entrada = r_calc_entrada;
  assign calc_codigo  = r_calc_codigo;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_index    = r_res_index;
  assign dbg_state    = r_state;
endmodule
